// File: rtl/ram_scan_pkg.sv
// Shared mode/state encodings and a constant clog2 for the RAM scan controller.
package ram_scan_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port RAM with registered read; a same-address write returns the old word.
module ram_sp_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Only the output register is cleared; the array keeps its contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_scan_ctrl.sv
// RAM controller with manual access, timed auto-scan for display and a whole-array fill.
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 5,
  parameter int                SCAN_DIV   = 25000000,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  input  logic [1:0]        mode,
  input  logic              start,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int DIV_W = clog2(SCAN_DIV);
  localparam int CNT_W = ADDR_W + 1;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  fill_cnt;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic              start_fill;
  logic              fill_last;
  logic              div_tc;

  assign start_fill = (state != ST_FILL) && (mode == MODE_FILL) && start;
  assign fill_last  = (fill_cnt == CNT_W'(DEPTH - 1));
  assign div_tc     = (div == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    ram_addr  = address;
    ram_wdata = data;
    ram_we    = wren;
    ram_re    = 1'b1;
    case (state)
      ST_SCAN: begin
        ram_addr = ptr;
        ram_we   = 1'b0;
      end
      ST_FILL: begin
        ram_addr  = fill_cnt[ADDR_W-1:0];
        ram_wdata = FILL_VALUE;
        ram_we    = 1'b1;
        ram_re    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_MANUAL;
      div      <= '0;
      ptr      <= '0;
      fill_cnt <= '0;
      cur_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cur_addr <= ram_addr;
      done     <= 1'b0;
      case (state)
        ST_MANUAL: begin
          if (start_fill) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            busy     <= 1'b1;
          end else if (mode == MODE_SCAN) begin
            state <= ST_SCAN;
            div   <= '0;
            ptr   <= '0;
          end
        end
        ST_SCAN: begin
          if (start_fill) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            busy     <= 1'b1;
          end else if (mode != MODE_SCAN) begin
            state <= ST_MANUAL;
          end else if (div_tc) begin
            div <= '0;
            ptr <= ptr + 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_last) begin
            state <= ST_MANUAL;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: state <= ST_MANUAL;
      endcase
    end
  end

  ram_sp_sync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock(clock),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .q    (q)
  );

endmodule

// File: doc/ram_scan_ctrl.md
Name: ram_scan_ctrl

Overview:
Parametrised single-port on-chip RAM with a small controller around it. It supersedes the fixed 32x8 RAM/display top, and the display and LED drivers now consume its outputs. It has three modes:
- Manual: read/write from the board switches.
- Auto-scan: steps through every address at a programmable rate so the contents can be watched on HEX/LEDs.
- Fill: clears or initialises the whole array in DEPTH cycles.

Parameters:
DATA_W, 8, RAM word width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
SCAN_DIV, 25000000, clock cycles per auto-scan step (must be at least 2)
FILL_VALUE, 0, DATA_W-bit value written to every word in fill mode

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset
address  input  ADDR_W  manual-mode address
data  input  DATA_W  manual-mode write data
wren  input  1  manual-mode write enable, level
mode  input  2  00 manual, 01 scan, 10 fill-armed, 11 reserved (behaves as manual)
start  input  1  starts a fill when mode=10 and not busy
q  output  DATA_W  RAM read data
cur_addr  output  ADDR_W  address currently driving the RAM, for display
busy  output  1  high while a fill is in progress
done  output  1  one-cycle pulse when a fill completes

Behaviour:
- Reset (reset=0, asynchronous):
  - q=0, cur_addr=0, busy=0, done=0.
  - State MANUAL; scan pointer=0; divider=0.
  - RAM contents are not reset.
- RAM timing:
  - Synchronous read; address registered at edge k, q valid after edge k (one-cycle latency).
  - Read-during-write to the same address returns OLD data on q.
- States: MANUAL, SCAN, FILL.
  - MANUAL→SCAN when mode=01: divider and scan pointer cleared to 0 on entry.
  - SCAN→MANUAL when mode≠01.
  - MANUAL or SCAN→FILL when mode=10 and start=1 are sampled together.
  - FILL→MANUAL after the last write; SCAN is re-entered next cycle if mode=01.
- MANUAL:
  - RAM address=address, wdata=data, we=wren.
  - cur_addr registered with the RAM address.
  - Mode 10 without start behaves as MANUAL.
- SCAN:
  - wren ignored; RAM we=0; address=scan pointer.
  - Divider counts 0..SCAN_DIV-1. At terminal count the divider returns to 0 and the pointer increments, wrapping DEPTH-1→0.
  - q shows mem[pointer] one cycle after each pointer change; cur_addr tracks the pointer.
- FILL:
  - busy=1 from the cycle after start is sampled, for exactly DEPTH cycles.
  - Writes FILL_VALUE to addresses 0,1,…,DEPTH-1, one per cycle; cur_addr follows the write address.
  - mode, start, wren and address are ignored during FILL.
  - After the write to DEPTH-1: busy=0 and done=1 for one cycle.
  - q holds its last value during FILL (read disabled).
  - start while busy is ignored; start with mode≠10 is ignored.
- Widths: counters sized as clog2(SCAN_DIV) and ADDR_W+1; all wrap logic explicit, no reliance on implicit overflow except the pointer at ADDR_W bits.
- Reset mid-FILL: fill aborts immediately; contents partially filled; no done pulse.

Decomposition:
- Shared package ram_scan_pkg holds:
  - mode constants MODE_MANUAL=2'b00, MODE_SCAN=2'b01, MODE_FILL=2'b10;
  - state encoding constants ST_MANUAL, ST_SCAN, ST_FILL;
  - a clog2 function.
- One sub-module ram_sp_sync (parameters DATA_W, ADDR_W): inferred single-port RAM with registered address, old-data read-during-write, no reset on the array.
- The controller (FSM, divider, pointer, fill counter, muxing) lives in ram_scan_ctrl.
- Seven-segment decode and LED driving remain external.

Test Plan:
1. Manual write/read: write 8'hA5 @3 and 8'h3C @4, then read 3 → q=8'hA5 one cycle after address=3; read 4 → 8'h3C.
2. Read-during-write: mem[7]=8'h11; wren=1, data=8'h22, address=7 → q=8'h11 that cycle; next read of 7 → 8'h22.
3. Scan with SCAN_DIV=4 and mem[i]=i: set mode=01 → cur_addr steps 0,1,2,… every 4 cycles, q=cur_addr one cycle later; wraps 31→0 after 128 cycles.
4. Fill with FILL_VALUE=8'hFF: mode=10, start=1 → busy high for 32 cycles, done pulses once. A manual read of addresses 0, 15 and 31 then returns 8'hFF.
5. Ignored inputs: start during fill and wren=1 during scan → no second fill, no RAM change.
6. Reset mid-fill: reset=0 at fill cycle 10 → outputs zero asynchronously; addresses 0..9 hold FILL_VALUE, address 10 and above hold their old data; no done pulse.
